qoi_decoder: RTL and testbench
==============================

Name: qoi_decoder

Overview:
- Memory-mapped QOI decode accelerator for the 6502 bus. It is the receive-side counterpart of the qoi encoder peripheral.
- The CPU writes encoded chunk bytes one at a time. The block runs the QOI chunk state machine, including the 64-entry index, the previous pixel and run expansion.
- It presents one decoded RGBA pixel at a time through a read/pop register set.
- It sits beside the encoder in the 0xA400 I/O window, selected by its own cs.

Parameters:
- ADDR_W, 4, register address width (16 byte registers).
- INIT_A, 8'hFF, alpha of the initial previous pixel (0,0,0,INIT_A).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cs  in  1  register select
- we  in  1  1 = CPU write, 0 = read
- addr  in  ADDR_W  register index
- data_i  in  8  CPU write data
- data_o  out  8  read data; combinational from addr, valid in the same cycle
- irq  out  1  high while pix_valid and IE

Behaviour:
- Register map:
  - 0: DATA (W) encoded byte in.
  - 1: STATUS (R): b0 in_ready, b1 pix_valid, b2 run_active, b3 overflow (sticky), b4 hdr_ok.
  - 2..5: PIX_R, PIX_G, PIX_B, PIX_A (R). A read of PIX_A pops the pixel.
  - 6: CTRL (W): b0 soft clear, b1 IE.
  - 7: RUN_LEFT (R).
  - 8..B: header width/height, low 16 bits each (optional feature).
  - Unused registers read 0.
- Bus side effects happen only on posedge clk with cs=1. Writes need we=1 and reads need we=0.
- Reset (rst or CTRL.b0):
  - index cleared to all-zero; prev = PIX regs = (0,0,0,INIT_A); FSM in OP; run_left = 0.
  - pix_valid = 0, overflow = 0, IE = 0 (IE is cleared by rst only); data_o = 0 when cs=0; irq = 0.
  - STATUS reads 0x01.
- FSM states: OP, RGB1..RGB3, RGBA1..RGBA4, LUMA2, RUN.
  - A byte is accepted only when in_ready = (state != RUN && !pix_valid).
  - A write while !in_ready drops the byte and sets overflow.
- Byte handling in OP:
  - 0xFE goes to RGB1. 0xFF goes to RGBA1.
  - 00iiiiii is INDEX: pixel = index[i].
  - 01rrggbb is DIFF: each channel += field-2, mod 256.
  - 10gggggg goes to LUMA2 and latches dg = g-32.
  - 11nnnnnn is RUN of n+1 pixels. 0xFE/0xFF are tested before RUN.
- Multi-byte chunks:
  - LUMA2 byte: r += dg + hi4-8; g += dg; b += dg + lo4-8; all mod 256.
  - RGB bytes overwrite R, G, B in order; alpha is kept. RGBA bytes overwrite R, G, B, A.
- Pixel completion:
  - The pixel completes on the edge of the chunk's final byte.
  - On that edge: PIX regs = prev = new pixel; pix_valid = 1; index[(r*3+g*5+b*7+a*11)%64] = new pixel.
  - The index is written after every chunk, including INDEX and RUN.
  - Pixel latency: 1 cycle after the last byte write.
- RUN:
  - Emits prev with pix_valid = 1 and run_left = n.
  - Each PIX_A pop decrements run_left and re-asserts pix_valid on the next cycle.
  - After the pop with run_left = 0, the FSM returns to OP.
- Pop with pix_valid = 0 is ignored.
- A DATA write on the same edge as the final pop is dropped, because in_ready was 0 on that cycle.
- The end marker is not detected. The CPU stops on its own pixel count.
- Async rst mid-chunk aborts the chunk with no partial pixel. A soft clear on the same edge as a DATA write wins.

Optional Feature:
- QOI_DEC_HEADER_EN defined:
  - The first 14 accepted bytes after reset are consumed as the header; no pixels are produced during it.
  - hdr_ok = magic "qoif"; else the overflow bit is set.
  - Width and height big-endian low 16 bits are readable at 8..B.
- QOI_DEC_HEADER_EN undefined: all bytes are chunks; hdr_ok and 8..B read 0.

Decomposition:
- Package qoi_pkg:
  - opcode constants (OP_RGB, OP_RGBA, 2-bit tags);
  - rgba_t packed struct;
  - register address localparams;
  - qoi_hash function (shared with the encoder).
- Sub-module qoi_dec_index: 64x32 register-file index with sync write, async read and clear input.

Test Plan:
1. Hard reset -> STATUS=0x01, PIX=00,00,00,FF, irq=0.
2. Write FE,10,20,30 -> STATUS=0x02, PIX=10,20,30,FF. Read PIX_A -> STATUS=0x01.
3. After case 2 pop:
   - write 0x79 -> PIX=11,20,2F,FF;
   - pop, then write A8,88 -> PIX=19,28,37,FF.
4. After case 2 pop, write 0x15 (hash 21) -> PIX=10,20,30,FF.
5. Write C2 -> RUN_LEFT=2, three pops each return prev; STATUS=0x01 only after the third pop.
6. Write FE with pix_valid=1 -> byte dropped, overflow=1. CTRL=01 -> STATUS=0x01, PIX=00,00,00,FF.

Source files
------------

// File: rtl/qoi_pkg.sv
// Shared QOI definitions: chunk opcodes, pixel type, register map,
// decoder FSM states and the colour hash used by encoder and decoder.
package qoi_pkg;

  localparam logic [7:0] OP_RGB  = 8'hFE;
  localparam logic [7:0] OP_RGBA = 8'hFF;

  localparam logic [1:0] TAG_INDEX = 2'b00;
  localparam logic [1:0] TAG_DIFF  = 2'b01;
  localparam logic [1:0] TAG_LUMA  = 2'b10;
  localparam logic [1:0] TAG_RUN   = 2'b11;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] a;
  } rgba_t;

  localparam int unsigned REG_DATA      = 0;
  localparam int unsigned REG_STATUS    = 1;
  localparam int unsigned REG_PIX_R     = 2;
  localparam int unsigned REG_PIX_G     = 3;
  localparam int unsigned REG_PIX_B     = 4;
  localparam int unsigned REG_PIX_A     = 5;
  localparam int unsigned REG_CTRL      = 6;
  localparam int unsigned REG_RUN_LEFT  = 7;
  localparam int unsigned REG_WIDTH_LO  = 8;
  localparam int unsigned REG_WIDTH_HI  = 9;
  localparam int unsigned REG_HEIGHT_LO = 10;
  localparam int unsigned REG_HEIGHT_HI = 11;

  typedef enum logic [3:0] {
    S_OP,
    S_RGB1,
    S_RGB2,
    S_RGB3,
    S_RGBA1,
    S_RGBA2,
    S_RGBA3,
    S_RGBA4,
    S_LUMA2,
    S_RUN
  } dec_state_t;

  // (r*3 + g*5 + b*7 + a*11) mod 64
  function automatic logic [5:0] qoi_hash(input rgba_t p);
    logic [31:0] s;
    s = 32'(p.r) * 32'd3 + 32'(p.g) * 32'd5 + 32'(p.b) * 32'd7 + 32'(p.a) * 32'd11;
    return s[5:0];
  endfunction

endpackage

// File: rtl/qoi_dec_index.sv
// 64-entry colour index: synchronous write, asynchronous read, clear input.
module qoi_dec_index
  import qoi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       we_i,
  input  logic [5:0] waddr_i,
  input  rgba_t      wdata_i,
  input  logic [5:0] raddr_i,
  output rgba_t      rdata_o
);

  rgba_t mem_q [64];

  // Storage update: reset/clear wipe every entry, else optional write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 64; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      for (int unsigned i = 0; i < 64; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/qoi_decoder.sv
// Memory-mapped QOI chunk decoder: CPU writes encoded bytes to DATA and
// pops decoded RGBA pixels from PIX_R..PIX_A.
// Optional header parsing is enabled with `define QOI_DEC_HEADER_EN.
module qoi_decoder
  import qoi_pkg::*;
#(
  parameter int         ADDR_W = 4,
  parameter logic [7:0] INIT_A = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_i,
  output logic [7:0]        data_o,
  output logic              irq
);

  localparam rgba_t PIX_INIT = '{r: 8'h00, g: 8'h00, b: 8'h00, a: INIT_A};

  dec_state_t  state_q, state_d;
  rgba_t       prev_q, prev_d, pix_q, pix_d, cur_q, cur_d;
  logic        pix_valid_q, pix_valid_d;
  logic        overflow_q, overflow_d;
  logic        ie_q, ie_d;
  logic [5:0]  run_left_q, run_left_d;
  logic [7:0]  dg_q, dg_d;

  logic [31:0] addr_ext;
  logic        in_ready, byte_acc, soft_clr;
  logic        done, idx_we;
  logic [5:0]  idx_waddr;
  rgba_t       new_pix, idx_rdata;
  logic        hdr_busy, hdr_ok, hdr_magic_fail;

  assign addr_ext = 32'(addr);
  assign in_ready = (state_q != S_RUN) && !pix_valid_q;
  assign byte_acc = cs && we && (addr_ext == REG_DATA) && in_ready;
  assign soft_clr = cs && we && (addr_ext == REG_CTRL) && data_i[0];
  assign irq      = pix_valid_q && ie_q;

  qoi_dec_index u_index (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (soft_clr),
    .we_i    (idx_we),
    .waddr_i (idx_waddr),
    .wdata_i (new_pix),
    .raddr_i (data_i[5:0]),
    .rdata_o (idx_rdata)
  );

`ifdef QOI_DEC_HEADER_EN
  logic [3:0]  hdr_cnt_q, hdr_cnt_d;
  logic        hdr_ok_q, hdr_ok_d;
  logic        magic_bad_q, magic_bad_d;
  logic [15:0] width_q, width_d, height_q, height_d;

  assign hdr_busy = (hdr_cnt_q != 4'd14);
  assign hdr_ok   = hdr_ok_q;

  // Header parser: magic check and big-endian low halves of width/height.
  always_comb begin
    hdr_cnt_d      = hdr_cnt_q;
    hdr_ok_d       = hdr_ok_q;
    magic_bad_d    = magic_bad_q;
    width_d        = width_q;
    height_d       = height_q;
    hdr_magic_fail = 1'b0;
    if (byte_acc && hdr_busy) begin
      hdr_cnt_d = hdr_cnt_q + 4'd1;
      case (hdr_cnt_q)
        4'd0:  magic_bad_d = (data_i != 8'h71);
        4'd1:  magic_bad_d = magic_bad_q | (data_i != 8'h6F);
        4'd2:  magic_bad_d = magic_bad_q | (data_i != 8'h69);
        4'd3: begin
          magic_bad_d    = magic_bad_q | (data_i != 8'h66);
          hdr_ok_d       = !magic_bad_d;
          hdr_magic_fail = magic_bad_d;
        end
        4'd6:  width_d[15:8]  = data_i;
        4'd7:  width_d[7:0]   = data_i;
        4'd10: height_d[15:8] = data_i;
        4'd11: height_d[7:0]  = data_i;
        default: ;
      endcase
    end
    if (soft_clr) begin
      hdr_cnt_d   = '0;
      hdr_ok_d    = 1'b0;
      magic_bad_d = 1'b0;
      width_d     = '0;
      height_d    = '0;
    end
  end

  // Header state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_cnt_q   <= '0;
      hdr_ok_q    <= 1'b0;
      magic_bad_q <= 1'b0;
      width_q     <= '0;
      height_q    <= '0;
    end else begin
      hdr_cnt_q   <= hdr_cnt_d;
      hdr_ok_q    <= hdr_ok_d;
      magic_bad_q <= magic_bad_d;
      width_q     <= width_d;
      height_q    <= height_d;
    end
  end
`else
  assign hdr_busy       = 1'b0;
  assign hdr_ok         = 1'b0;
  assign hdr_magic_fail = 1'b0;
`endif

  // Chunk FSM next state, pixel assembly and bus side effects.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    pix_d       = pix_q;
    cur_d       = cur_q;
    pix_valid_d = pix_valid_q;
    overflow_d  = overflow_q;
    ie_d        = ie_q;
    run_left_d  = run_left_q;
    dg_d        = dg_q;
    new_pix     = prev_q;
    done        = 1'b0;

    // Pop: inside a run the same pixel stays valid until run_left is spent.
    if (cs && !we && (addr_ext == REG_PIX_A) && pix_valid_q) begin
      if (state_q == S_RUN) begin
        if (run_left_q == '0) begin
          state_d     = S_OP;
          pix_valid_d = 1'b0;
        end else begin
          run_left_d  = run_left_q - 6'd1;
          pix_valid_d = 1'b1;
        end
      end else begin
        pix_valid_d = 1'b0;
      end
    end

    if (cs && we && (addr_ext == REG_DATA) && !in_ready) overflow_d = 1'b1;
    if (hdr_magic_fail) overflow_d = 1'b1;

    if (byte_acc && !hdr_busy) begin
      case (state_q)
        S_OP: begin
          if (data_i == OP_RGB) begin
            cur_d   = prev_q;
            state_d = S_RGB1;
          end else if (data_i == OP_RGBA) begin
            cur_d   = prev_q;
            state_d = S_RGBA1;
          end else begin
            case (data_i[7:6])
              TAG_INDEX: begin
                new_pix = idx_rdata;
                done    = 1'b1;
              end
              TAG_DIFF: begin
                new_pix.r = prev_q.r + {6'b0, data_i[5:4]} - 8'd2;
                new_pix.g = prev_q.g + {6'b0, data_i[3:2]} - 8'd2;
                new_pix.b = prev_q.b + {6'b0, data_i[1:0]} - 8'd2;
                done      = 1'b1;
              end
              TAG_LUMA: begin
                dg_d    = {2'b0, data_i[5:0]} - 8'd32;
                state_d = S_LUMA2;
              end
              TAG_RUN: begin
                run_left_d = data_i[5:0];
                state_d    = S_RUN;
                done       = 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_RGB1:  begin cur_d.r = data_i; state_d = S_RGB2;  end
        S_RGB2:  begin cur_d.g = data_i; state_d = S_RGB3;  end
        S_RGB3: begin
          new_pix = '{r: cur_q.r, g: cur_q.g, b: data_i, a: prev_q.a};
          done    = 1'b1;
          state_d = S_OP;
        end
        S_RGBA1: begin cur_d.r = data_i; state_d = S_RGBA2; end
        S_RGBA2: begin cur_d.g = data_i; state_d = S_RGBA3; end
        S_RGBA3: begin cur_d.b = data_i; state_d = S_RGBA4; end
        S_RGBA4: begin
          new_pix = '{r: cur_q.r, g: cur_q.g, b: cur_q.b, a: data_i};
          done    = 1'b1;
          state_d = S_OP;
        end
        S_LUMA2: begin
          new_pix.r = prev_q.r + dg_q + {4'b0, data_i[7:4]} - 8'd8;
          new_pix.g = prev_q.g + dg_q;
          new_pix.b = prev_q.b + dg_q + {4'b0, data_i[3:0]} - 8'd8;
          done      = 1'b1;
          state_d   = S_OP;
        end
        default: ;
      endcase
    end

    if (done) begin
      pix_d       = new_pix;
      prev_d      = new_pix;
      pix_valid_d = 1'b1;
    end

    if (cs && we && (addr_ext == REG_CTRL)) ie_d = data_i[1];

    if (soft_clr) begin
      state_d     = S_OP;
      prev_d      = PIX_INIT;
      pix_d       = PIX_INIT;
      cur_d       = PIX_INIT;
      pix_valid_d = 1'b0;
      overflow_d  = 1'b0;
      run_left_d  = '0;
      dg_d        = '0;
      done        = 1'b0;
    end
  end

  assign idx_we    = done;
  assign idx_waddr = qoi_hash(new_pix);

  // Decoder state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_OP;
      prev_q      <= PIX_INIT;
      pix_q       <= PIX_INIT;
      cur_q       <= PIX_INIT;
      pix_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      ie_q        <= 1'b0;
      run_left_q  <= '0;
      dg_q        <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      pix_q       <= pix_d;
      cur_q       <= cur_d;
      pix_valid_q <= pix_valid_d;
      overflow_q  <= overflow_d;
      ie_q        <= ie_d;
      run_left_q  <= run_left_d;
      dg_q        <= dg_d;
    end
  end

  // Combinational read mux.
  always_comb begin
    data_o = '0;
    if (cs) begin
      case (addr_ext)
        REG_STATUS:    data_o = {3'b0, hdr_ok, overflow_q, (state_q == S_RUN), pix_valid_q, in_ready};
        REG_PIX_R:     data_o = pix_q.r;
        REG_PIX_G:     data_o = pix_q.g;
        REG_PIX_B:     data_o = pix_q.b;
        REG_PIX_A:     data_o = pix_q.a;
        REG_RUN_LEFT:  data_o = {2'b0, run_left_q};
`ifdef QOI_DEC_HEADER_EN
        REG_WIDTH_LO:  data_o = width_q[7:0];
        REG_WIDTH_HI:  data_o = width_q[15:8];
        REG_HEIGHT_LO: data_o = height_q[7:0];
        REG_HEIGHT_HI: data_o = height_q[15:8];
`else
        REG_WIDTH_LO, REG_WIDTH_HI, REG_HEIGHT_LO, REG_HEIGHT_HI: data_o = '0;
`endif
        default:       data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_qoi_decoder.sv
// Bench for qoi_decoder: directed register-level steps followed by a random
// chunk stream checked against a behavioural pixel model.
module tb_qoi_decoder;

  logic       clk;
  logic       rst;
  logic       cs;
  logic       we;
  logic [3:0] addr;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       irq;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: previous pixel and colour index as packed {r,g,b,a}.
  logic [31:0] m_prev;
  logic [31:0] m_idx [64];

  qoi_decoder #(.ADDR_W(4), .INIT_A(8'hFF)) dut (
    .clk    (clk),
    .rst    (rst),
    .cs     (cs),
    .we     (we),
    .addr   (addr),
    .data_i (data_i),
    .data_o (data_o),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mhash(input logic [31:0] p);
    return (int'(p[31:24]) * 3 + int'(p[23:16]) * 5 + int'(p[15:8]) * 7 + int'(p[7:0]) * 11) % 64;
  endfunction

  task automatic model_reset();
    m_prev = 32'h000000FF;
    for (int i = 0; i < 64; i++) m_idx[i] = 32'h0;
  endtask

  task automatic model_emit(input logic [31:0] px);
    m_prev = px;
    m_idx[mhash(px)] = px;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a[3:0]; data_i = d;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0;
  endtask

  // Read without crossing a clock edge, so no side effect.
  task automatic rd(input int a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = a[3:0];
    #1;
    d = data_o;
    #1;
    cs = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = 4'd5;
    @(posedge clk);
    #1;
    cs = 1'b0;
  endtask

  task automatic check_pix(input string tag, input logic [31:0] exp);
    logic [7:0] r, g, b, a;
    rd(2, r); rd(3, g); rd(4, b); rd(5, a);
    chk(tag, {r, g, b, a}, exp);
  endtask

  task automatic check_reg(input string tag, input int a, input logic [7:0] exp);
    logic [7:0] v;
    rd(a, v);
    chk(tag, {24'h0, v}, {24'h0, exp});
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; data_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_reg("rst_status", 1, 8'h01);
    check_pix("rst_pix", 32'h000000FF);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    check_reg("rst_runleft", 7, 8'h00);
    check_reg("rst_width", 8, 8'h00);

    // Pop with nothing valid is ignored
    pop();
    check_reg("idle_pop_status", 1, 8'h01);

    // RGB chunk
    wr(0, 8'hFE); wr(0, 8'h10); wr(0, 8'h20); wr(0, 8'h30);
    model_emit(32'h102030FF);
    check_reg("rgb_status", 1, 8'h02);
    check_pix("rgb_pix", 32'h102030FF);
    pop();
    check_reg("rgb_pop_status", 1, 8'h01);

    // DIFF then LUMA
    wr(0, 8'h79);
    model_emit(32'h11202FFF);
    check_pix("diff_pix", 32'h11202FFF);
    pop();
    wr(0, 8'hA8); wr(0, 8'h88);
    model_emit(32'h192837FF);
    check_pix("luma_pix", 32'h192837FF);
    pop();

    // INDEX hit on the RGB pixel (hash 21)
    wr(0, 8'h15);
    model_emit(32'h102030FF);
    check_pix("index_pix", 32'h102030FF);
    pop();

    // RUN of 3
    wr(0, 8'hC2);
    model_emit(32'h102030FF);
    check_reg("run_left0", 7, 8'd2);
    check_reg("run_status0", 1, 8'h06);
    check_pix("run_pix0", 32'h102030FF);
    pop();
    check_reg("run_left1", 7, 8'd1);
    check_pix("run_pix1", 32'h102030FF);
    pop();
    check_reg("run_left2", 7, 8'd0);
    check_reg("run_status2", 1, 8'h06);
    check_pix("run_pix2", 32'h102030FF);
    pop();
    check_reg("run_done_status", 1, 8'h01);

    // Interrupt enable
    wr(6, 8'h02);
    chk("irq_idle", {31'h0, irq}, 32'h0);
    wr(0, 8'h6A);
    chk("irq_on", {31'h0, irq}, 32'h1);
    check_pix("diff_zero_pix", 32'h102030FF);

    // Overflow on write while a pixel is pending, then soft clear
    wr(0, 8'hFE);
    check_reg("ovf_status", 1, 8'h0A);
    check_pix("ovf_pix", 32'h102030FF);
    wr(6, 8'h01);
    model_reset();
    check_reg("clr_status", 1, 8'h01);
    check_pix("clr_pix", 32'h000000FF);
    chk("clr_irq", {31'h0, irq}, 32'h0);
    wr(0, 8'h15);
    check_pix("clr_index", 32'h00000000);
    model_emit(32'h00000000);
    pop();

    // Random chunk stream against the model
    for (int c = 0; c < 60; c++) begin
      int kind, npx, n, dr, dgr, db, dgv, rdg, bdg;
      logic [7:0] r8, g8, b8, a8;
      logic [7:0] bq[$];
      logic [31:0] px;
      kind = $urandom_range(0, 5);
      npx = 1;
      px = m_prev;
      bq.delete();
      r8 = 8'($urandom); g8 = 8'($urandom); b8 = 8'($urandom); a8 = 8'($urandom);
      case (kind)
        0: begin
          bq.push_back(8'hFE); bq.push_back(r8); bq.push_back(g8); bq.push_back(b8);
          px = {r8, g8, b8, m_prev[7:0]};
        end
        1: begin
          bq.push_back(8'hFF); bq.push_back(r8); bq.push_back(g8); bq.push_back(b8);
          bq.push_back(a8);
          px = {r8, g8, b8, a8};
        end
        2: begin
          n = $urandom_range(0, 63);
          bq.push_back(8'(n));
          px = m_idx[n];
        end
        3: begin
          dr = $urandom_range(0, 3); dgr = $urandom_range(0, 3); db = $urandom_range(0, 3);
          bq.push_back(8'(64 + dr * 16 + dgr * 4 + db));
          px = {8'(int'(m_prev[31:24]) + dr - 2), 8'(int'(m_prev[23:16]) + dgr - 2),
                8'(int'(m_prev[15:8]) + db - 2), m_prev[7:0]};
        end
        4: begin
          dgv = $urandom_range(0, 63); rdg = $urandom_range(0, 15); bdg = $urandom_range(0, 15);
          bq.push_back(8'(128 + dgv));
          bq.push_back(8'(rdg * 16 + bdg));
          px = {8'(int'(m_prev[31:24]) + dgv - 32 + rdg - 8),
                8'(int'(m_prev[23:16]) + dgv - 32),
                8'(int'(m_prev[15:8]) + dgv - 32 + bdg - 8), m_prev[7:0]};
        end
        default: begin
          n = $urandom_range(0, 5);
          bq.push_back(8'(192 + n));
          npx = n + 1;
        end
      endcase
      for (int k = 0; k < bq.size(); k++) wr(0, bq[k]);
      model_emit(px);
      for (int p = 0; p < npx; p++) begin
        check_reg("rnd_status", 1, (kind >= 5) ? 8'h06 : 8'h02);
        check_pix("rnd_pix", px);
        pop();
      end
      check_reg("rnd_idle", 1, 8'h01);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
